camera_sequencer: RTL and testbench

Parametrised exposure/readout sequencer for the pixel-array camera front end. It holds a user-adjustable exposure time and, on `init`, runs one frame: erase release, exposure, then row-by-row readout with active-low row enables and an ADC strobe per row. An optional continuous mode chains frames with a timed erase between them. It sits between the user control inputs and the analogue pixel array / ADC.

---
 rtl/camera_pkg.sv | 24 ++
 rtl/exp_time_reg.sv | 39 +++
 rtl/camera_sequencer.sv | 160 ++++++++++++++++
 tb/tb_camera_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared types and default constants for the camera exposure/readout sequencer.
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPOSE,
    READOUT,
    ERASE
  } state_e;

  localparam int N_ROWS_DEF       = 2;
  localparam int EXP_W_DEF        = 5;
  localparam int EXP_RESET_DEF    = 16;
  localparam int EXP_MIN_DEF      = 2;
  localparam int EXP_MAX_DEF      = 30;
  localparam int ADC_CYCLES_DEF   = 2;
  localparam int ERASE_CYCLES_DEF = 4;

  // One readout slot: setup cycle, ADC strobe cycles, hold cycle.
  function automatic int slot_len(input int adcCycles);
    return adcCycles + 2;
  endfunction

endpackage

// File: rtl/exp_time_reg.sv
// Saturating up/down exposure-time register; adjusts only while enabled.
module exp_time_reg #(
  parameter int EXP_W     = 5,
  parameter int EXP_RESET = 16,
  parameter int EXP_MIN   = 2,
  parameter int EXP_MAX   = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  output logic [EXP_W-1:0] value
);

  logic [EXP_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (en) begin
      if (inc && !dec && (value_q < EXP_W'(EXP_MAX))) begin
        value_d = value_q + EXP_W'(1);
      end else if (dec && !inc && (value_q > EXP_W'(EXP_MIN))) begin
        value_d = value_q - EXP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= EXP_W'(EXP_RESET);
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/camera_sequencer.sv
// Frame sequencer: erase release, exposure countdown, then row-by-row readout
// with an ADC strobe per row; optional continuous mode with timed erase.
module camera_sequencer
  import camera_pkg::*;
#(
  parameter int N_ROWS       = N_ROWS_DEF,
  parameter int EXP_W        = EXP_W_DEF,
  parameter int EXP_RESET    = EXP_RESET_DEF,
  parameter int EXP_MIN      = EXP_MIN_DEF,
  parameter int EXP_MAX      = EXP_MAX_DEF,
  parameter int ADC_CYCLES   = ADC_CYCLES_DEF,
  parameter int ERASE_CYCLES = ERASE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              cont,
  input  logic              exp_increase,
  input  logic              exp_decrease,
  output logic [N_ROWS-1:0] nre,
  output logic              adc,
  output logic              expose,
  output logic              erase,
  output logic              busy,
  output logic              frame_done,
  output logic [EXP_W-1:0]  exp_time
);

  localparam int SLOT    = slot_len(ADC_CYCLES);
  localparam int CNT_MAX = (SLOT > ERASE_CYCLES) ? SLOT : ERASE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ROW_W   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  state_e            state_q, state_d;
  logic [EXP_W-1:0]  expCnt_q, expCnt_d;
  logic [CNT_W-1:0]  slotCnt_q, slotCnt_d;
  logic [ROW_W-1:0]  row_q, row_d;

  logic [N_ROWS-1:0] nre_q, nre_d;
  logic              adc_q, adc_d;
  logic              expose_q, expose_d;
  logic              erase_q, erase_d;
  logic              busy_q, busy_d;
  logic              frameDone_q, frameDone_d;

  logic [EXP_W-1:0]  expTime;
  logic              expEn;

  // Adjustments are only accepted while idle and not being overridden by init.
  assign expEn = (state_q == IDLE) && !init;

  exp_time_reg #(
    .EXP_W     (EXP_W),
    .EXP_RESET (EXP_RESET),
    .EXP_MIN   (EXP_MIN),
    .EXP_MAX   (EXP_MAX)
  ) u_exp_time_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (expEn),
    .inc   (exp_increase),
    .dec   (exp_decrease),
    .value (expTime)
  );

  always_comb begin
    state_d     = state_q;
    expCnt_d    = expCnt_q;
    slotCnt_d   = slotCnt_q;
    row_d       = row_q;
    frameDone_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (init) begin
          state_d  = EXPOSE;
          expCnt_d = expTime;
        end
      end
      EXPOSE: begin
        if (expCnt_q <= EXP_W'(1)) begin
          state_d   = READOUT;
          row_d     = '0;
          slotCnt_d = '0;
        end else begin
          expCnt_d = expCnt_q - EXP_W'(1);
        end
      end
      READOUT: begin
        if (slotCnt_q == CNT_W'(SLOT - 1)) begin
          slotCnt_d = '0;
          if (row_q == ROW_W'(N_ROWS - 1)) begin
            frameDone_d = 1'b1;
            state_d     = cont ? ERASE : IDLE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          slotCnt_d = slotCnt_q + CNT_W'(1);
        end
      end
      ERASE: begin
        if (slotCnt_q == CNT_W'(ERASE_CYCLES - 1)) begin
          state_d   = EXPOSE;
          expCnt_d  = expTime;
          slotCnt_d = '0;
        end else begin
          slotCnt_d = slotCnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    nre_d = '1;
    if (state_d == READOUT) begin
      nre_d[row_d] = 1'b0;
    end
    adc_d    = (state_d == READOUT) && (slotCnt_d >= CNT_W'(1)) &&
               (slotCnt_d <= CNT_W'(ADC_CYCLES));
    expose_d = (state_d == EXPOSE);
    erase_d  = (state_d == IDLE) || (state_d == ERASE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      expCnt_q    <= '0;
      slotCnt_q   <= '0;
      row_q       <= '0;
      nre_q       <= '1;
      adc_q       <= 1'b0;
      expose_q    <= 1'b0;
      erase_q     <= 1'b1;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      expCnt_q    <= expCnt_d;
      slotCnt_q   <= slotCnt_d;
      row_q       <= row_d;
      nre_q       <= nre_d;
      adc_q       <= adc_d;
      expose_q    <= expose_d;
      erase_q     <= erase_d;
      busy_q      <= busy_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign nre        = nre_q;
  assign adc        = adc_q;
  assign expose     = expose_q;
  assign erase      = erase_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;
  assign exp_time   = expTime;

endmodule

// File: tb/tb_camera_sequencer.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// cycle-offset reference model of the frame timing.
module tb_camera_sequencer;

  localparam int N_ROWS = 2;
  localparam int ADC    = 2;
  localparam int SLOT   = ADC + 2;
  localparam int ERASEC = 4;
  localparam int EXPRST = 16;
  localparam int EXPMIN = 2;
  localparam int EXPMAX = 30;

  logic              clk;
  logic              rst_n;
  logic              init;
  logic              cont;
  logic              exp_increase;
  logic              exp_decrease;
  logic [N_ROWS-1:0] nre;
  logic              adc;
  logic              expose;
  logic              erase;
  logic              busy;
  logic              frame_done;
  logic [4:0]        exp_time;

  int testsRun;
  int testsFailed;

  // Reference model: frame progress as a plain offset from the frame start.
  bit mIdle;
  bit mErasing;
  bit mDone;
  int mT;
  int mE;
  int mEraseT;
  int mExp;

  camera_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init         (init),
    .cont         (cont),
    .exp_increase (exp_increase),
    .exp_decrease (exp_decrease),
    .nre          (nre),
    .adc          (adc),
    .expose       (expose),
    .erase        (erase),
    .busy         (busy),
    .frame_done   (frame_done),
    .exp_time     (exp_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelStep(input logic r, input logic i, input logic c,
                           input logic up, input logic dn);
    mDone = 0;
    if (!r) begin
      mIdle = 1; mErasing = 0; mExp = EXPRST;
    end else if (mIdle) begin
      if (i) begin
        mIdle = 0; mErasing = 0; mT = 0; mE = mExp;
      end else if (up && !dn) begin
        mExp = (mExp + 1 > EXPMAX) ? EXPMAX : mExp + 1;
      end else if (dn && !up) begin
        mExp = (mExp - 1 < EXPMIN) ? EXPMIN : mExp - 1;
      end
    end else if (mErasing) begin
      mEraseT++;
      if (mEraseT == ERASEC) begin
        mErasing = 0; mT = 0; mE = mExp;
      end
    end else begin
      mT++;
      if (mT == mE + N_ROWS * SLOT) begin
        mDone = 1;
        if (c) begin
          mErasing = 1; mEraseT = 0;
        end else begin
          mIdle = 1;
        end
      end
    end
  endtask

  task automatic checkAgainstModel();
    logic [N_ROWS-1:0] eNre;
    logic eAdc, eExp, eErase, eBusy;
    int r, p;
    eNre = '1; eAdc = 0; eExp = 0; eErase = 1; eBusy = 0;
    if (!mIdle) begin
      eBusy = 1;
      if (!mErasing) begin
        eErase = 0;
        if (mT < mE) begin
          eExp = 1;
        end else begin
          r = (mT - mE) / SLOT;
          p = (mT - mE) % SLOT;
          eNre[r] = 1'b0;
          eAdc = (p >= 1) && (p <= ADC);
        end
      end
    end
    checkOutput("nre", 32'(nre), 32'(eNre));
    checkOutput("adc", 32'(adc), 32'(eAdc));
    checkOutput("expose", 32'(expose), 32'(eExp));
    checkOutput("erase", 32'(erase), 32'(eErase));
    checkOutput("busy", 32'(busy), 32'(eBusy));
    checkOutput("frame_done", 32'(frame_done), 32'(mDone));
    checkOutput("exp_time", 32'(exp_time), 32'(mExp));
  endtask

  task automatic applyStimulus(input logic r, input logic i, input logic c,
                               input logic up, input logic dn);
    rst_n = r; init = i; cont = c; exp_increase = up; exp_decrease = dn;
    @(posedge clk);
    modelStep(r, i, c, up, dn);
    @(negedge clk);
    checkAgainstModel();
  endtask

  // Runs idle-input cycles until frame_done; returns cycles taken (bound+1 on timeout).
  task automatic waitDone(input logic c, input logic up, input logic dn, output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1'b1, 1'b0, c, up, dn);
      n++;
      if (frame_done) return;
    end
    n = 101;
  endtask

  initial begin
    int n;
    testsRun = 0;
    testsFailed = 0;
    mIdle = 1; mErasing = 0; mDone = 0; mT = 0; mE = 0; mEraseT = 0; mExp = EXPRST;
    rst_n = 0; init = 0; cont = 0; exp_increase = 0; exp_decrease = 0;

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rstNre", 32'(nre), 32'h3);
    checkOutput("rstErase", 32'(erase), 32'h1);
    checkOutput("rstExpTime", 32'(exp_time), 32'd16);

    // Default single frame.
    applyStimulus(1, 1, 0, 0, 0);
    waitDone(0, 0, 0, n);
    checkOutput("frameLen16", 32'(n), 32'd24);
    checkOutput("eraseAfterFrame", 32'(erase), 32'h1);

    // Saturation.
    for (int k = 0; k < 20; k++) applyStimulus(1, 0, 0, 1, 0);
    checkOutput("satMax", 32'(exp_time), 32'd30);
    for (int k = 0; k < 40; k++) applyStimulus(1, 0, 0, 0, 1);
    checkOutput("satMin", 32'(exp_time), 32'd2);
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("incDecBoth", 32'(exp_time), 32'd2);

    // Shortest exposure.
    applyStimulus(1, 1, 0, 0, 0);
    waitDone(0, 0, 0, n);
    checkOutput("frameLen2", 32'(n), 32'd10);
    for (int k = 0; k < 14; k++) applyStimulus(1, 0, 0, 1, 0);
    checkOutput("expBack16", 32'(exp_time), 32'd16);

    // Continuous mode; dropping cont mid-erase still finishes the committed frame.
    applyStimulus(1, 1, 1, 0, 0);
    waitDone(1, 0, 0, n);
    checkOutput("contFirst", 32'(n), 32'd24);
    waitDone(1, 0, 0, n);
    checkOutput("contPeriod", 32'(n), 32'd28);
    applyStimulus(1, 0, 0, 0, 0);
    waitDone(0, 0, 0, n);
    checkOutput("contLast", 32'(n), 32'd27);
    checkOutput("idleAfterCont", 32'(busy), 32'h0);

    // Reset during row 1 readout.
    applyStimulus(1, 1, 0, 0, 0);
    for (int k = 0; k < 21; k++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("row1Low", 32'(nre), 32'h1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("abortNre", 32'(nre), 32'h3);
    checkOutput("abortAdc", 32'(adc), 32'h0);
    checkOutput("abortBusy", 32'(busy), 32'h0);

    // init beats increment; adjustments ignored during the frame.
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("initWinsInc", 32'(exp_time), 32'd16);
    for (int k = 0; k < 6; k++) applyStimulus(1, 1, 0, 1, 0);
    waitDone(0, 1, 0, n);
    checkOutput("frameIgnoresInputs", 32'(n), 32'd18);
    checkOutput("expStable", 32'(exp_time), 32'd16);

    // Random stimulus against the model.
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
                    ($urandom_range(0, 9) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
